// File: rtl/iir_coeff_loader.sv
// Serial IIR coefficient loader: collects a b/a frame into a shadow bank and
// swaps it into the active bank atomically on a sample-boundary strobe.

module iir_coeff_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         swap,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] shadow;

  // ld and swap are mutually exclusive: beats are refused while a swap is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      q      <= '0;
    end else begin
      if (ld)   shadow <= d;
      if (swap) q      <= shadow;
    end
  end
endmodule

module iir_coeff_loader #(
  parameter int M           = 2,
  parameter int COEFF_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COEFF_WIDTH-1:0]   wr_data,
  input  logic                     wr_valid,
  input  logic                     wr_last,
  output logic                     wr_ready,
  input  logic                     update_en,
  output logic [COEFF_WIDTH*(M+1)-1:0] packed_b_coeffs,
  output logic [COEFF_WIDTH*M-1:0]     packed_a_coeffs,
  output logic                     pending,
  output logic                     updated,
  output logic                     frame_err
);
  localparam int N     = M + 1;
  localparam int L     = 2*M + 1;
  localparam int LAST  = 2*M;
  localparam int IDX_W = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, ARMED} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             err_nxt, swap, fire, collecting, at_last;

  assign fire       = wr_valid && wr_ready;
  assign collecting = (state == IDLE) || (state == LOAD);
  assign at_last    = (idx == IDX_W'(LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      frame_err <= 1'b0;
      updated   <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      frame_err <= err_nxt;
      updated   <= swap;
    end
  end

  // IDLE behaves as LOAD at idx 0, which also covers the degenerate L==1 case
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = 1'b0;
    swap      = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (fire) begin
          if (at_last) begin
            idx_nxt   = '0;
            state_nxt = wr_last ? ARMED : DRAIN;
            err_nxt   = !wr_last;
          end else if (wr_last) begin
            idx_nxt   = '0;
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = LOAD;
          end
        end
      end
      DRAIN: begin
        if (fire && wr_last) state_nxt = IDLE;
      end
      ARMED: begin
        if (update_en) begin
          swap      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (state != ARMED);
    pending  = (state == ARMED);
  end

  logic [L-1:0][COEFF_WIDTH-1:0] slot_q;
  logic                          shadow_we;

  assign shadow_we = fire && collecting;

  for (genvar t = 0; t < L; t++) begin : g_slot
    iir_coeff_slot #(.W(COEFF_WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (shadow_we && (idx == IDX_W'(t))),
      .swap  (swap),
      .d     (wr_data),
      .q     (slot_q[t])
    );
    if (t < N) begin : g_b
      assign packed_b_coeffs[COEFF_WIDTH*t +: COEFF_WIDTH] = slot_q[t];
    end else begin : g_a
      assign packed_a_coeffs[COEFF_WIDTH*(t-N) +: COEFF_WIDTH] = slot_q[t];
    end
  end
endmodule
